// File: rtl/regfile_write_port.sv
// Register-file write-port arbiter: pipeline writeback has priority, late results
// drain in order from a small queue, and queued values are forwarded to decode.
module regfile_write_port #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             pw_en,
    input  logic [4:0]       pw_rd,
    input  logic [WIDTH-1:0] pw_data,
    input  logic             enq_valid,
    input  logic [4:0]       enq_rd,
    input  logic [WIDTH-1:0] enq_data,
    output logic             enq_ready,
    input  logic [4:0]       RA,
    input  logic [4:0]       RB,
    output logic             hitA,
    output logic [WIDTH-1:0] fwdA,
    output logic             hitB,
    output logic [WIDTH-1:0] fwdB,
    output logic [4:0]       RW,
    output logic [WIDTH-1:0] BusW,
    output logic             RegWr,
    output logic             pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid;
    logic [4:0]       ent_rd   [DEPTH];
    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic          pw_write;
    logic          drain;
    logic          enq_fire;
    logic          enq_store;
    logic [PW-1:0] fwd_idx;

    always_comb begin
        pw_write  = !Rst && pw_en && (pw_rd != '0);
        drain     = !Rst && !pw_write && (count != '0);
        enq_ready = !Rst && (count < CW'(DEPTH));
        enq_fire  = enq_valid && enq_ready;
        enq_store = enq_fire && (enq_rd != '0);
        pending   = (count != '0);

        RegWr = 1'b0;
        RW    = '0;
        BusW  = '0;
        if (pw_write) begin
            RegWr = 1'b1;
            RW    = pw_rd;
            BusW  = pw_data;
        end else if (drain && valid[head]) begin
            RegWr = 1'b1;
            RW    = ent_rd[head];
            BusW  = ent_data[head];
        end
    end

    // Scan oldest to youngest so the last match is the youngest entry.
    always_comb begin
        hitA    = 1'b0;
        fwdA    = '0;
        hitB    = 1'b0;
        fwdB    = '0;
        fwd_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PW'(k);
            if (valid[fwd_idx] && (ent_rd[fwd_idx] == RA) && (RA != '0)) begin
                hitA = 1'b1;
                fwdA = ent_data[fwd_idx];
            end
            if (valid[fwd_idx] && (ent_rd[fwd_idx] == RB) && (RB != '0)) begin
                hitB = 1'b1;
                fwdB = ent_data[fwd_idx];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ent_rd[k]   <= '0;
                ent_data[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (pw_write && valid[k] && (ent_rd[k] == pw_rd))
                    valid[k] <= 1'b0;
            end
            if (drain) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            // Tail slot is free whenever we store, so the new entry overrides any kill.
            if (enq_store) begin
                valid[tail]    <= 1'b1;
                ent_rd[tail]   <= enq_rd;
                ent_data[tail] <= enq_data;
                tail           <= tail + 1'b1;
            end
            case ({enq_store, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed checks of the regfile write-port arbiter followed by a short
// pseudo-random run against a queue model.
module tb_regfile_write_port;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        pw_en;
    logic [4:0]  pw_rd;
    logic [31:0] pw_data;
    logic        enq_valid;
    logic [4:0]  enq_rd;
    logic [31:0] enq_data;
    logic        enq_ready;
    logic [4:0]  RA, RB;
    logic        hitA, hitB;
    logic [31:0] fwdA, fwdB;
    logic [4:0]  RW;
    logic [31:0] BusW;
    logic        RegWr;
    logic        pending;

    int total = 0;
    int bad   = 0;

    regfile_write_port #(.DEPTH(4), .WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst),
        .pw_en(pw_en), .pw_rd(pw_rd), .pw_data(pw_data),
        .enq_valid(enq_valid), .enq_rd(enq_rd), .enq_data(enq_data),
        .enq_ready(enq_ready),
        .RA(RA), .RB(RB),
        .hitA(hitA), .fwdA(fwdA), .hitB(hitB), .fwdB(fwdB),
        .RW(RW), .BusW(BusW), .RegWr(RegWr), .pending(pending)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] arch_rf [32];
    logic [31:0] dut_rf  [32];

    initial begin
        Rst = 1'b1; pw_en = 0; pw_rd = 0; pw_data = 0;
        enq_valid = 0; enq_rd = 0; enq_data = 0; RA = 0; RB = 0;

        // reset state
        #2;
        chk("rst_regwr", RegWr, 0);
        chk("rst_rw", RW, 0);
        chk("rst_busw", BusW, 0);
        chk("rst_pending", pending, 0);
        chk("rst_hita", hitA, 0);
        chk("rst_hitb", hitB, 0);
        step();
        Rst = 1'b0;
        #2;
        chk("idle_ready", enq_ready, 1);
        chk("idle_regwr", RegWr, 0);

        // single late write
        enq_valid = 1; enq_rd = 5; enq_data = 32'hDEADBEEF;
        #2;
        chk("single_pre_regwr", RegWr, 0);
        step();
        enq_valid = 0;
        #2;
        chk("single_regwr", RegWr, 1);
        chk("single_rw", RW, 5);
        chk("single_busw", BusW, 32'hDEADBEEF);
        chk("single_pending", pending, 1);
        step();
        #2;
        chk("single_after_pending", pending, 0);
        chk("single_after_regwr", RegWr, 0);

        // fill under pipeline priority
        for (int i = 0; i < 4; i++) begin
            pw_en = 1; pw_rd = 5'(i + 1); pw_data = 32'h100 + i;
            enq_valid = 1; enq_rd = 5'(8 + i); enq_data = 32'h10 + i;
            #2;
            chk("fill_ready", enq_ready, 1);
            chk("fill_regwr", RegWr, 1);
            chk("fill_rw", RW, i + 1);
            chk("fill_busw", BusW, 32'h100 + i);
            step();
        end
        pw_en = 0; enq_valid = 1; enq_rd = 20; enq_data = 32'h99;
        #2;
        chk("full_ready", enq_ready, 0);
        chk("drain0_rw", RW, 8);
        chk("drain0_busw", BusW, 32'h10);
        step();
        enq_valid = 0;
        for (int i = 1; i < 4; i++) begin
            #2;
            chk("drain_regwr", RegWr, 1);
            chk("drain_rw", RW, 8 + i);
            chk("drain_busw", BusW, 32'h10 + i);
            step();
        end
        #2;
        chk("drain_done_pending", pending, 0);

        // kill: queued rd=7 overtaken by pipeline, same-cycle enqueue survives
        pw_en = 1; pw_rd = 1; pw_data = 32'h1;
        enq_valid = 1; enq_rd = 7; enq_data = 32'hAA;
        step();
        pw_rd = 7; pw_data = 32'hBB; enq_data = 32'hCC; RA = 7;
        #2;
        chk("kill_pre_hita", hitA, 1);
        chk("kill_pre_fwda", fwdA, 32'hAA);
        chk("kill_pw_rw", RW, 7);
        chk("kill_pw_busw", BusW, 32'hBB);
        step();
        pw_en = 0; enq_valid = 0;
        #2;
        chk("kill_post_fwda", fwdA, 32'hCC);
        chk("kill_drain_regwr", RegWr, 0);
        chk("kill_drain_pending", pending, 1);
        step();
        #2;
        chk("kill_young_regwr", RegWr, 1);
        chk("kill_young_rw", RW, 7);
        chk("kill_young_busw", BusW, 32'hCC);
        step();
        #2;
        chk("kill_done_pending", pending, 0);

        // forwarding, rd=0 enqueue, and pw_rd=0 drain
        pw_en = 1; pw_rd = 1; enq_valid = 1; enq_rd = 3; enq_data = 32'h11;
        step();
        enq_data = 32'h22;
        step();
        enq_valid = 0; RA = 3; RB = 0;
        #2;
        chk("fwd_hita", hitA, 1);
        chk("fwd_fwda", fwdA, 32'h22);
        chk("fwd_hitb_zero", hitB, 0);
        chk("fwd_fwdb_zero", fwdB, 0);
        RB = 3;
        #1;
        chk("fwd_hitb", hitB, 1);
        chk("fwd_fwdb", fwdB, 32'h22);
        enq_valid = 1; enq_rd = 0; enq_data = 32'h55;
        step();
        enq_valid = 0; pw_rd = 0; pw_data = 32'h77;
        #2;
        chk("rd0_pending", pending, 1);
        chk("pwrd0_regwr", RegWr, 1);
        chk("pwrd0_rw", RW, 3);
        chk("pwrd0_busw", BusW, 32'h11);
        step();
        #2;
        chk("pwrd0_busw2", BusW, 32'h22);
        step();
        #2;
        chk("rd0_not_stored", pending, 0);
        RA = 0; RB = 0;

        // reset mid-operation
        pw_en = 1; pw_rd = 1; enq_valid = 1; enq_rd = 9; enq_data = 1;
        step();
        enq_rd = 10;
        step();
        enq_valid = 0;
        #1;
        chk("midrst_pre_pending", pending, 1);
        Rst = 1;
        #1;
        chk("midrst_pending", pending, 0);
        chk("midrst_regwr", RegWr, 0);
        step();
        Rst = 0; pw_en = 0;
        #2;
        chk("midrst_after_regwr", RegWr, 0);
        chk("midrst_after_ready", enq_ready, 1);

        // pseudo-random run against a queue model
        for (int r = 0; r < 32; r++) begin
            arch_rf[r] = '0;
            dut_rf[r]  = '0;
        end
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        e_wr, e_chk_addr, e_ha, e_hb, pw_w;
            logic [4:0]  e_rw;
            logic [31:0] e_bus, e_fa, e_fb;
            Rst       = (cyc % 10 == 9);
            pw_en     = ($urandom_range(0, 9) < 4);
            pw_rd     = 5'($urandom_range(0, 7));
            pw_data   = $urandom;
            enq_valid = ($urandom_range(0, 9) < 6);
            enq_rd    = 5'($urandom_range(0, 7));
            enq_data  = $urandom;
            RA        = 5'($urandom_range(0, 7));
            RB        = 5'($urandom_range(0, 7));
            if (Rst) q.delete();
            #2;
            pw_w = !Rst && pw_en && (pw_rd != 0);
            e_wr = 0; e_rw = 0; e_bus = 0; e_chk_addr = 1;
            if (pw_w) begin
                e_wr = 1; e_rw = pw_rd; e_bus = pw_data;
            end else if (!Rst && q.size() > 0) begin
                if (q[0].v) begin
                    e_wr = 1; e_rw = q[0].rd; e_bus = q[0].d;
                end else begin
                    e_chk_addr = 0;
                end
            end
            e_ha = 0; e_fa = 0; e_hb = 0; e_fb = 0;
            foreach (q[i]) begin
                if (q[i].v && q[i].rd == RA && RA != 0) begin e_ha = 1; e_fa = q[i].d; end
                if (q[i].v && q[i].rd == RB && RB != 0) begin e_hb = 1; e_fb = q[i].d; end
            end
            chk("soak_regwr", RegWr, e_wr);
            if (e_chk_addr) begin
                chk("soak_rw", RW, e_rw);
                chk("soak_busw", BusW, e_bus);
            end
            chk("soak_ready", enq_ready, !Rst && q.size() < 4);
            chk("soak_pending", pending, q.size() != 0);
            chk("soak_hita", hitA, e_ha);
            chk("soak_fwda", fwdA, e_fa);
            chk("soak_hitb", hitB, e_hb);
            chk("soak_fwdb", fwdB, e_fb);
            if (e_wr) arch_rf[e_rw] = e_bus;
            if (RegWr) dut_rf[RW] = BusW;
            @(posedge Clk);
            if (!Rst) begin
                logic can_enq;
                can_enq = q.size() < 4;
                if (pw_w)
                    foreach (q[i]) if (q[i].v && q[i].rd == pw_rd) q[i].v = 0;
                if (!pw_w && q.size() > 0) void'(q.pop_front());
                if (enq_valid && can_enq && enq_rd != 0)
                    q.push_back('{v: 1'b1, rd: enq_rd, d: enq_data});
            end
            #1;
        end
        for (int r = 0; r < 32; r++)
            chk("soak_regfile", dut_rf[r], arch_rf[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
